rx_edge_slicer: RTL
===================

Name: rx_edge_slicer

Overview:
- Sits directly downstream of the IQ synthesis / FIR stage in the Rx module.
- Consumes one filtered signed 12-bit baseband channel and removes its DC component with a tracking average.
- Slices the result to a binary level with hysteresis.
- Reports every level transition with its polarity and the sample interval since the previous transition. The FM0/Miller decoder uses these reports for symbol timing.

Parameters:
- DATA_W, 12, input sample width (signed)
- AVG_SHIFT, 6, DC tracker time constant = 2^AVG_SHIFT samples
- HYST, 32, hysteresis threshold in LSBs, applied symmetrically about DC
- SETTLE_N, 16, samples after enable during which edges are suppressed
- CNT_W, 10, interval counter width
- TIMEOUT, 1023, interval saturation value (≤ 2^CNT_W−1)

Ports:
- clk_i  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rx_enable_i  in  1  receive window; low = block idle and cleared
- sample_en_i  in  1  one-cycle strobe, data_i valid
- data_i  in  DATA_W  signed filtered sample (FIR output)
- level_o  out  1  sliced level
- edge_o  out  1  one-cycle pulse on level transition
- edge_pol_o  out  1  new level at last edge (1 = rising)
- interval_o  out  CNT_W  samples since previous edge, valid with edge_o, held otherwise
- timeout_o  out  1  one-cycle pulse when the interval saturates
- dc_o  out  DATA_W  current DC estimate (signed)
- settled_o  out  1  high in TRACK state

Behaviour:
- Reset (async, rst_n low): every output is 0, the accumulator is 0, the counters are 0, and the FSM is in IDLE.
- FSM states: IDLE, PRIME, SETTLE, TRACK.
  - IDLE → PRIME when rx_enable_i = 1.
  - PRIME: on the first sample_en_i, load acc = data_i <<< AVG_SHIFT (sign-extended), settle_cnt = 1, then go to SETTLE.
  - SETTLE: update acc on each sample. Go to TRACK on the sample where settle_cnt reaches SETTLE_N. No edges are emitted, and level_o follows the slicer rule silently.
  - TRACK: full operation.
  - Any state → IDLE on the clock after rx_enable_i = 0. This clears acc, the counters, level_o, interval_o, edge_pol_o and dc_o. Samples arriving while rx_enable_i = 0 are ignored.
- DC tracker, per accepted sample:
  - acc (DATA_W+AVG_SHIFT+1 bits, signed) <= acc + data_i − (acc >>> AVG_SHIFT).
  - dc_o = acc >>> AVG_SHIFT, registered.
- Slicer:
  - diff = data_i − dc_o, computed at DATA_W+1 bits using the dc value from before this sample's update.
  - diff > HYST → level 1; diff < −HYST → level 0; otherwise level holds.
- Latency: a sample strobed at cycle N updates level_o, edge_o, interval_o and dc_o at cycle N+1.
- Interval counter (TRACK only):
  - Each accepted sample does cnt <= cnt + 1, saturating at TIMEOUT.
  - On an edge: interval_o <= min(cnt+1, TIMEOUT), edge_pol_o <= new level, edge_o = 1, cnt <= 0.
  - The first edge after entering TRACK reports the samples since TRACK entry. cnt starts at 0 on entry.
- Timeout:
  - When cnt+1 first equals TIMEOUT without an edge on that sample, timeout_o pulses once.
  - No further pulses occur until the next edge.
  - If an edge and saturation happen on the same sample, the edge wins and timeout_o stays 0.
- No back-pressure. Consecutive sample_en_i on every cycle is legal.

Test Plan:
1. Reset check: assert rst_n low mid-run with toggling input → all outputs read 0 immediately. After release, the block waits for rx_enable_i.
2. Priming: enable, then feed a constant 100 on every cycle → dc_o = 100 from the first update. settled_o rises after 16 samples. No edge_o.
3. Square wave: ±500 around 0, 8 samples high / 8 low, after settling → edge_o every 8 samples with interval_o = 8 and edge_pol_o alternating. The first edge reports the samples since TRACK entry. dc_o stays within ±80.
4. Hysteresis: DC established at 0, then input toggles ±20 every sample → no edge_o, level_o constant. Next, a +40 step → one rising edge.
5. Timeout: one edge, then a constant input for 1100 samples → a single timeout_o pulse on sample 1023. The next edge reports interval_o = 1023.
6. Enable drop: deassert rx_enable_i mid-burst → next clock settled_o, level_o and dc_o are 0 and no edges occur. Re-enabling with a constant −200 → dc_o = −200 after the first sample.

Source files
------------

// File: rtl/rx_edge_slicer.sv
// Receive-path edge slicer: removes DC with a tracking average, slices with
// hysteresis and reports each level transition with polarity and interval.
module rx_edge_slicer #(
    parameter int DATA_W    = 12,
    parameter int AVG_SHIFT = 6,
    parameter int HYST      = 32,
    parameter int SETTLE_N  = 16,
    parameter int CNT_W     = 10,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              rx_enable_i,
    input  logic              sample_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              level_o,
    output logic              edge_o,
    output logic              edge_pol_o,
    output logic [CNT_W-1:0]  interval_o,
    output logic              timeout_o,
    output logic [DATA_W-1:0] dc_o,
    output logic              settled_o
);

    localparam int ACC_W = DATA_W + AVG_SHIFT + 1;
    localparam int SC_W  = $clog2(SETTLE_N + 1);

    localparam logic [CNT_W:0]             TMO         = (CNT_W + 1)'(TIMEOUT);
    localparam logic [SC_W-1:0]            SETTLE_LAST = SC_W'(SETTLE_N);
    localparam logic [SC_W-1:0]            SC_ONE      = SC_W'(1);
    localparam logic signed [DATA_W:0]     HYST_POS    = (DATA_W + 1)'(HYST);
    localparam logic signed [DATA_W:0]     HYST_NEG    = (DATA_W + 1)'(-HYST);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_TRACK  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  dc_q, dc_d;
    logic                      level_q, level_d;
    logic                      edge_q, edge_d;
    logic                      pol_q, pol_d;
    logic [CNT_W-1:0]          interval_q, interval_d;
    logic                      timeout_q, timeout_d;
    logic                      settled_q, settled_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SC_W-1:0]           settle_cnt_q, settle_cnt_d;

    logic signed [ACC_W-1:0]   data_ext_s;
    logic signed [ACC_W-1:0]   acc_prime_s;
    logic signed [ACC_W-1:0]   acc_upd_s;
    logic signed [DATA_W:0]    diff_s;
    logic                      slice_s;
    logic [CNT_W:0]            cnt_inc_s;
    logic [CNT_W-1:0]          cnt_sat_s;

    // Hysteresis slicer: only a clear excursion beyond the band moves the level.
    function automatic logic slice_level(input logic signed [DATA_W:0] diff,
                                         input logic                   cur);
        if (diff > HYST_POS) begin
            return 1'b1;
        end else if (diff < HYST_NEG) begin
            return 1'b0;
        end else begin
            return cur;
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W:0] inc);
        if (inc >= TMO) begin
            return TMO[CNT_W-1:0];
        end else begin
            return inc[CNT_W-1:0];
        end
    endfunction

    // Datapath: tracker update, slicer difference and interval increment.
    always_comb begin
        data_ext_s  = {{(ACC_W - DATA_W){data_i[DATA_W-1]}}, data_i};
        acc_prime_s = data_ext_s <<< AVG_SHIFT;
        acc_upd_s   = acc_q + data_ext_s - (acc_q >>> AVG_SHIFT);
        diff_s      = $signed({data_i[DATA_W-1], data_i}) - $signed({dc_q[DATA_W-1], dc_q});
        slice_s     = slice_level(diff_s, level_q);
        cnt_inc_s   = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        cnt_sat_s   = sat_count(cnt_inc_s);
    end

    // Next-state logic for the FSM and every registered output.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        level_d      = level_q;
        edge_d       = 1'b0;
        pol_d        = pol_q;
        interval_d   = interval_q;
        timeout_d    = 1'b0;
        cnt_d        = cnt_q;
        settle_cnt_d = settle_cnt_q;

        if (!rx_enable_i) begin
            state_d      = ST_IDLE;
            acc_d        = '0;
            level_d      = 1'b0;
            pol_d        = 1'b0;
            interval_d   = '0;
            cnt_d        = '0;
            settle_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PRIME;
                end
                // The level holds on the priming sample: there is no DC estimate yet.
                ST_PRIME: begin
                    if (sample_en_i) begin
                        acc_d        = acc_prime_s;
                        settle_cnt_d = SC_ONE;
                        if (SC_ONE >= SETTLE_LAST) begin
                            state_d = ST_TRACK;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_SETTLE;
                        end
                    end else begin
                        state_d = ST_PRIME;
                    end
                end
                ST_SETTLE: begin
                    if (sample_en_i) begin
                        acc_d        = acc_upd_s;
                        level_d      = slice_s;
                        settle_cnt_d = settle_cnt_q + SC_ONE;
                        if ((settle_cnt_q + SC_ONE) == SETTLE_LAST) begin
                            state_d = ST_TRACK;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_SETTLE;
                        end
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_TRACK: begin
                    if (sample_en_i) begin
                        acc_d   = acc_upd_s;
                        level_d = slice_s;
                        if (slice_s != level_q) begin
                            edge_d     = 1'b1;
                            pol_d      = slice_s;
                            interval_d = cnt_sat_s;
                            cnt_d      = '0;
                        end else begin
                            cnt_d     = cnt_sat_s;
                            timeout_d = (cnt_inc_s == TMO);
                        end
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Arithmetic shift then truncate is just a bit slice of the accumulator.
        dc_d      = acc_d[AVG_SHIFT +: DATA_W];
        settled_d = (state_d == ST_TRACK);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            dc_q         <= '0;
            level_q      <= 1'b0;
            edge_q       <= 1'b0;
            pol_q        <= 1'b0;
            interval_q   <= '0;
            timeout_q    <= 1'b0;
            settled_q    <= 1'b0;
            cnt_q        <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            dc_q         <= dc_d;
            level_q      <= level_d;
            edge_q       <= edge_d;
            pol_q        <= pol_d;
            interval_q   <= interval_d;
            timeout_q    <= timeout_d;
            settled_q    <= settled_d;
            cnt_q        <= cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign level_o    = level_q;
    assign edge_o     = edge_q;
    assign edge_pol_o = pol_q;
    assign interval_o = interval_q;
    assign timeout_o  = timeout_q;
    assign dc_o       = dc_q;
    assign settled_o  = settled_q;

endmodule
